tx_packet_scheduler: RTL and testbench

TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

---
 rtl/tx_packet_scheduler.sv | 174 +++++++++++++++++
 tb/tb_tx_packet_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_scheduler.sv
// Symbol-lane scheduler: round-robin TLP/DLLP byte arbitration behind a single output register.
// Define TX_SCHED_SKP_INSERT_EN to build periodic SKP ordered-set insertion (COM + SKP_COUNT x SKP).
module tx_packet_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tlp_data_i,
  input  logic       tlp_valid_i,
  input  logic       tlp_last_i,
  output logic       tlp_ready_o,
  input  logic [7:0] dllp_data_i,
  input  logic       dllp_valid_i,
  input  logic       dllp_last_i,
  output logic       dllp_ready_o,
  output logic [7:0] data_frame_o,
  output logic       data_frame_valid_o,
  output logic       is_special_k_o,
  output logic       bypass_scrambler_o,
  input  logic       ds_ready_i
);

  if (SKP_INTERVAL < 8 || SKP_INTERVAL > 65535 || SKP_COUNT < 1 || SKP_COUNT > 5) begin : g_bad_cfg
    $error("tx_packet_scheduler: SKP_INTERVAL or SKP_COUNT out of range");
  end

`ifdef TX_SCHED_SKP_INSERT_EN
  typedef enum logic [1:0] {IDLE, TLP, DLLP, SKP} state_t;
`else
  typedef enum logic [1:0] {IDLE, TLP, DLLP} state_t;
`endif

  state_t     state, state_nxt;
  logic       last_tlp, last_tlp_nxt;  // 1: TLP held the most recent grant
  logic [7:0] frame_q;
  logic       frame_valid_q;
  logic       can_load;
  logic       load;
  logic [7:0] load_data;

  assign can_load = !frame_valid_q || ds_ready_i;

`ifdef TX_SCHED_SKP_INSERT_EN
  localparam logic [15:0] CNT_LAST = 16'(SKP_INTERVAL - 1);
  localparam logic [2:0]  SKP_LAST = 3'(SKP_COUNT);

  logic [15:0] sym_cnt;
  logic        skp_pending;
  logic [2:0]  skp_idx;
  logic        k_q;
  logic        load_k;
  logic        skp_done;
  logic        data_xfer;
  logic        wrap;
  logic        skp_due;

  // K symbols only ever come from the SKP state, so k_q marks symbols excluded from the count
  assign data_xfer = frame_valid_q && ds_ready_i && !k_q;
  assign wrap      = data_xfer && (sym_cnt == CNT_LAST);
  assign skp_due   = skp_pending || wrap;
`endif

  always_comb begin
    state_nxt    = state;
    last_tlp_nxt = last_tlp;
    tlp_ready_o  = 1'b0;
    dllp_ready_o = 1'b0;
    load         = 1'b0;
    load_data    = 8'h00;
`ifdef TX_SCHED_SKP_INSERT_EN
    load_k       = 1'b0;
    skp_done     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef TX_SCHED_SKP_INSERT_EN
        if (skp_due) state_nxt = SKP;
        else
`endif
        if (tlp_valid_i && (!dllp_valid_i || !last_tlp)) begin
          state_nxt    = TLP;
          last_tlp_nxt = 1'b1;
        end else if (dllp_valid_i) begin
          state_nxt    = DLLP;
          last_tlp_nxt = 1'b0;
        end
      end
      TLP: begin
        tlp_ready_o = can_load;
        if (tlp_valid_i && can_load) begin
          load      = 1'b1;
          load_data = tlp_data_i;
          if (tlp_last_i) state_nxt = IDLE;
        end
      end
      DLLP: begin
        dllp_ready_o = can_load;
        if (dllp_valid_i && can_load) begin
          load      = 1'b1;
          load_data = dllp_data_i;
          if (dllp_last_i) state_nxt = IDLE;
        end
      end
`ifdef TX_SCHED_SKP_INSERT_EN
      SKP: begin
        if (can_load) begin
          load      = 1'b1;
          load_k    = 1'b1;
          load_data = (skp_idx == 3'd0) ? 8'hBC : 8'h1C;
          if (skp_idx == SKP_LAST) begin
            skp_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      last_tlp      <= 1'b0;
      frame_q       <= 8'h00;
      frame_valid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_tlp <= last_tlp_nxt;
      if (load) begin
        frame_q       <= load_data;
        frame_valid_q <= 1'b1;
      end else if (ds_ready_i) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

`ifdef TX_SCHED_SKP_INSERT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q         <= 1'b0;
      sym_cnt     <= 16'd0;
      skp_pending <= 1'b0;
      skp_idx     <= 3'd0;
    end else begin
      if (load) k_q <= load_k;
      else if (ds_ready_i) k_q <= 1'b0;
      if (load && state == SKP) skp_idx <= skp_done ? 3'd0 : skp_idx + 3'd1;
      if (skp_done) skp_pending <= 1'b0;
      // a wrap while a request is already pending simply re-sets the same flag
      if (data_xfer) begin
        if (wrap) begin
          sym_cnt     <= 16'd0;
          skp_pending <= 1'b1;
        end else begin
          sym_cnt <= sym_cnt + 16'd1;
        end
      end
    end
  end

  assign is_special_k_o     = k_q;
  assign bypass_scrambler_o = k_q;
`else
  assign is_special_k_o     = 1'b0;
  assign bypass_scrambler_o = 1'b0;
`endif

  assign data_frame_o       = frame_q;
  assign data_frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler; SKP scenarios are built only with TX_SCHED_SKP_INSERT_EN.
module tb_tx_packet_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] tlp_data_i, dllp_data_i;
  logic       tlp_valid_i, tlp_last_i, tlp_ready_o;
  logic       dllp_valid_i, dllp_last_i, dllp_ready_o;
  logic [7:0] data_frame_o;
  logic       data_frame_valid_o, is_special_k_o, bypass_scrambler_o;
  logic       ds_ready_i;

  always #5 clk_i = ~clk_i;

  tx_packet_scheduler #(.SKP_INTERVAL(8), .SKP_COUNT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tlp_data_i(tlp_data_i), .tlp_valid_i(tlp_valid_i), .tlp_last_i(tlp_last_i), .tlp_ready_o(tlp_ready_o),
    .dllp_data_i(dllp_data_i), .dllp_valid_i(dllp_valid_i), .dllp_last_i(dllp_last_i), .dllp_ready_o(dllp_ready_o),
    .data_frame_o(data_frame_o), .data_frame_valid_o(data_frame_valid_o),
    .is_special_k_o(is_special_k_o), .bypass_scrambler_o(bypass_scrambler_o), .ds_ready_i(ds_ready_i)
  );

  logic [7:0] tlp_mem  [0:2047];
  logic       tlp_lst  [0:2047];
  logic [7:0] dllp_mem [0:63];
  logic       dllp_lst [0:63];
  int         tlp_len, tlp_ptr, dllp_len, dllp_ptr;

  logic [9:0] rx_all[$];
  logic [7:0] rx_data[$];
  int         k_seen, byp_seen;
  int         n_checks = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    tlp_valid_i = (tlp_ptr < tlp_len);
    tlp_data_i  = 8'h00;
    tlp_last_i  = 1'b0;
    if (tlp_valid_i) begin
      tlp_data_i = tlp_mem[tlp_ptr];
      tlp_last_i = tlp_lst[tlp_ptr];
    end
    dllp_valid_i = (dllp_ptr < dllp_len);
    dllp_data_i  = 8'h00;
    dllp_last_i  = 1'b0;
    if (dllp_valid_i) begin
      dllp_data_i = dllp_mem[dllp_ptr];
      dllp_last_i = dllp_lst[dllp_ptr];
    end
  endtask

  task automatic clear_src();
    tlp_len = 0; tlp_ptr = 0; dllp_len = 0; dllp_ptr = 0;
    rx_all.delete(); rx_data.delete(); k_seen = 0; byp_seen = 0;
    drive_src();
  endtask

  task automatic push_tlp(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      tlp_mem[tlp_len] = 8'(base + i);
      tlp_lst[tlp_len] = (i == len - 1);
      tlp_len++;
    end
    drive_src();
  endtask

  task automatic push_dllp(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      dllp_mem[dllp_len] = 8'(base + i);
      dllp_lst[dllp_len] = (i == len - 1);
      dllp_len++;
    end
    drive_src();
  endtask

  // sample handshakes and the output lane mid-cycle, advance sources just after the edge
  task automatic step();
    logic tf, df;
    @(negedge clk_i);
    tf = tlp_valid_i && tlp_ready_o;
    df = dllp_valid_i && dllp_ready_o;
    if (data_frame_valid_o && ds_ready_i) begin
      rx_all.push_back({is_special_k_o, bypass_scrambler_o, data_frame_o});
      if (!is_special_k_o) rx_data.push_back(data_frame_o);
      if (is_special_k_o) k_seen++;
      if (bypass_scrambler_o) byp_seen++;
    end
    @(posedge clk_i);
    #1;
    if (tf) tlp_ptr++;
    if (df) dllp_ptr++;
    drive_src();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic run_until(input string tag, input int n, input bit use_all, input int budget);
    for (int c = 0; c < budget; c++) begin
      if ((use_all ? rx_all.size() : rx_data.size()) >= n) break;
      step();
    end
    check(tag, 32'(use_all ? rx_all.size() : rx_data.size()), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame"}, 32'(data_frame_o), 32'h00);
    check({tag, "_valid"}, 32'(data_frame_valid_o), 32'h0);
    check({tag, "_k"},     32'(is_special_k_o), 32'h0);
    check({tag, "_byp"},   32'(bypass_scrambler_o), 32'h0);
    check({tag, "_trdy"},  32'(tlp_ready_o), 32'h0);
    check({tag, "_drdy"},  32'(dllp_ready_o), 32'h0);
  endtask

  initial begin
    logic [7:0] exp_a [12];
    logic [7:0] exp_c [8];
    logic [9:0] e;
    int bad;

    rst_i = 1'b1;
    ds_ready_i = 1'b1;
    clear_src();

    // both sources contend straight out of reset
    push_tlp(8'hA0, 4); push_tlp(8'hA4, 4);
    push_dllp(8'hD0, 2); push_dllp(8'hD2, 2);
    step(); step();
    check_reset_outputs("rst");
    rst_i = 1'b0;
    check("idle_rdy_pre_edge", 32'(tlp_ready_o), 32'h0);
    step();
    check("first_grant_tlp", 32'(tlp_ready_o), 32'h1);
    check("first_grant_dllp_rdy", 32'(dllp_ready_o), 32'h0);
    check("first_grant_no_out", 32'(data_frame_valid_o), 32'h0);
    run_until("tie_count", 12, 1'b0, 100);
    exp_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hD0, 8'hD1, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hD2, 8'hD3};
    for (int i = 0; i < 12 && i < rx_data.size(); i++)
      check($sformatf("tie_sym%0d", i), 32'(rx_data[i]), 32'(exp_a[i]));
`ifndef TX_SCHED_SKP_INSERT_EN
    check("tie_k_seen", 32'(k_seen), 32'h0);
`endif
    repeat (4) step();
    check("drain_idle", 32'(data_frame_valid_o), 32'h0);

    // downstream backpressure mid-TLP
    clear_src();
    do_reset();
    push_tlp(8'hB0, 4);
    for (int c = 0; c < 20; c++) begin
      step();
      if (data_frame_valid_o && data_frame_o == 8'hB1) break;
    end
    check("bp_reach", 32'(data_frame_o), 32'hB1);
    ds_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_frame%0d", i), 32'(data_frame_o), 32'hB1);
      check($sformatf("bp_hold_valid%0d", i), 32'(data_frame_valid_o), 32'h1);
      check($sformatf("bp_hold_trdy%0d", i), 32'(tlp_ready_o), 32'h0);
    end
    check("bp_src_held", 32'(tlp_ptr), 32'd2);
    ds_ready_i = 1'b1;
    run_until("bp_count", 4, 1'b0, 30);
    for (int i = 0; i < 4 && i < rx_data.size(); i++)
      check($sformatf("bp_sym%0d", i), 32'(rx_data[i]), 32'(8'hB0 + i));
    repeat (3) step();
    check("bp_no_dup", 32'(rx_data.size()), 32'd4);

    // single-byte packets from both sources alternate strictly
    clear_src();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_tlp(8'(8'h30 + i), 1);
      push_dllp(8'(8'h50 + i), 1);
    end
    run_until("alt_count", 8, 1'b0, 60);
    exp_c = '{8'h30, 8'h50, 8'h31, 8'h51, 8'h32, 8'h52, 8'h33, 8'h53};
    for (int i = 0; i < 8 && i < rx_data.size(); i++)
      check($sformatf("alt_sym%0d", i), 32'(rx_data[i]), 32'(exp_c[i]));

`ifndef TX_SCHED_SKP_INSERT_EN
    // long run with random downstream stalls: no K symbol may ever appear
    clear_src();
    do_reset();
    for (int p = 0; p < 400; p++) push_tlp(8'(p * 5), 5);
    for (int c = 0; c < 8000 && rx_data.size() < 2000; c++) begin
      ds_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    ds_ready_i = 1'b1;
    check("long_count", 32'(rx_data.size()), 32'd2000);
    bad = 0;
    for (int j = 0; j < rx_data.size(); j++)
      if (rx_data[j] !== 8'(j)) bad++;
    check("long_bad_bytes", 32'(bad), 32'd0);
    check("long_k_seen", 32'(k_seen), 32'd0);
    check("long_byp_seen", 32'(byp_seen), 32'd0);
`else
    // SKP insertion after every 8 data symbols, never splitting a TLP
    clear_src();
    do_reset();
    for (int p = 0; p < 6; p++) push_tlp(8'(8'h40 + 3 * p), 3);
    run_until("skp_count", 26, 1'b1, 200);
    for (int i = 0; i < 26 && i < rx_all.size(); i++) begin
      if (i < 9)                e = {2'b00, 8'(8'h40 + i)};
      else if (i == 9 || i == 22) e = {2'b11, 8'hBC};
      else if (i < 13 || i > 22)  e = {2'b11, 8'h1C};
      else                        e = {2'b00, 8'(8'h40 + i - 4)};
      check($sformatf("skp_sym%0d", i), 32'(rx_all[i]), 32'(e));
    end

    // async reset while the second SKP-set symbol is on the lane
    clear_src();
    do_reset();
    for (int p = 0; p < 6; p++) push_tlp(8'(8'h60 + 3 * p), 3);
    for (int c = 0; c < 100; c++) begin
      step();
      if (data_frame_valid_o && is_special_k_o && data_frame_o == 8'h1C) break;
    end
    check("rst_skp_reach", 32'(data_frame_o), 32'h1C);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("rst_mid_skp");
    step();
    rst_i = 1'b0;
    clear_src();
    for (int p = 0; p < 4; p++) push_tlp(8'(8'h70 + 3 * p), 3);
    run_until("rst_skp_count", 10, 1'b1, 100);
    for (int i = 0; i < 10 && i < rx_all.size(); i++) begin
      e = (i < 9) ? {2'b00, 8'(8'h70 + i)} : {2'b11, 8'hBC};
      check($sformatf("rst_skp_sym%0d", i), 32'(rx_all[i]), 32'(e));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
